// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the radix-4 Booth multipliers (sequential and
// single-cycle variants):
//   state_e      - control states of the sequential multiplier
//   booth_dig_e  - recoded radix-4 Booth digit
//   n_dig()      - number of Booth digits retired for a given operand width
//   decode_digit - maps a 3-bit multiplier window to its Booth digit
// -----------------------------------------------------------------------------
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_dig_e;

  // One extra digit beyond width/2 covers the sign/zero extension bits, so
  // signed and unsigned operands share a single schedule.
  function automatic int n_dig(input int width);
    return width / 2 + 1;
  endfunction

  // Window is {b[2i+1], b[2i], b[2i-1]}.
  function automatic booth_dig_e decode_digit(input logic [2:0] win);
    booth_dig_e dig;
    case (win)
      3'b001, 3'b010: dig = POS1;
      3'b011:         dig = POS2;
      3'b100:         dig = NEG2;
      3'b101, 3'b110: dig = NEG1;
      default:        dig = ZERO;  // 3'b000, 3'b111
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// -----------------------------------------------------------------------------
// booth_r4_digit
// Combinational radix-4 Booth digit selector. Turns a 3-bit multiplier window
// into the signed addend 0, +A, +2A, -A or -2A.
// Ports:
//   win    in  3          multiplier window {b[2i+1], b[2i], b[2i-1]}
//   a_ext  in  WIDTH+1    extended multiplicand (two's complement)
//   addend out WIDTH+3    signed addend, two's complement
// -----------------------------------------------------------------------------
module booth_r4_digit
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       win,
  input  logic [WIDTH:0]   a_ext,
  output logic [WIDTH+2:0] addend
);

  logic [WIDTH+2:0] a_x1;
  logic [WIDTH+2:0] a_x2;

  assign a_x1 = {{2{a_ext[WIDTH]}}, a_ext};
  assign a_x2 = {a_ext[WIDTH], a_ext, 1'b0};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    addend = '0;
    case (decode_digit(win))
      POS1:    addend = a_x1;
      POS2:    addend = a_x2;
      NEG1:    addend = -a_x1;
      NEG2:    addend = -a_x2;
      default: addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_mul.sv
// -----------------------------------------------------------------------------
// booth_seq_mul
// Sequential radix-4 Booth multiplier, one Booth digit per clock, with
// valid/ready handshakes on both sides and a pass-through tag.
// Ports:
//   clk, rst_n          clock; synchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   a, b                multiplicand / multiplier (WIDTH bits)
//   alu_signed          1 = two's complement operands, 0 = unsigned
//   in_tag              transaction tag, returned on out_tag
//   out_valid/out_ready product handshake (out_valid high only in DONE)
//   prod_msb, prod_lsb  product bits [2W-1:W] / [W-1:0]
//   out_tag             tag of the presented product
// Latency: N_DIG = WIDTH/2+1 clocks from acceptance to out_valid.
// -----------------------------------------------------------------------------
module booth_seq_mul
  import booth_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             alu_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] prod_msb,
  output logic [WIDTH-1:0] prod_lsb,
  output logic [TAG_W-1:0] out_tag
);

  localparam int N_DIG = n_dig(WIDTH);
  localparam int CNT_W = $clog2(N_DIG + 1);
  localparam int ACC_W = WIDTH + 3;  // upper accumulator
  localparam int LO_W  = WIDTH + 2;  // receives 2 bits per digit, N_DIG digits
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(N_DIG - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LO_W-1:0]  lo_q, lo_d;
  logic [WIDTH:0]   a_q, a_d;      // extended multiplicand
  logic [ACC_W-1:0] b_q, b_d;      // {extended multiplier, b[-1]}; window at [2:0]
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] sum;
  logic             a_ext_bit;
  logic             b_ext_bit;

  booth_r4_digit #(
    .WIDTH(WIDTH)
  ) u_digit (
    .win   (b_q[2:0]),
    .a_ext (a_q),
    .addend(addend)
  );

  assign sum       = acc_q + addend;
  assign a_ext_bit = alu_signed & a[WIDTH-1];
  assign b_ext_bit = alu_signed & b[WIDTH-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = {a_ext_bit, a};
          b_d     = {b_ext_bit, b_ext_bit, b, 1'b0};
          tag_d   = in_tag;
          acc_d   = '0;
          lo_d    = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        // Add the digit, then arithmetic-shift {acc, lo} right by two. After
        // N_DIG digits {acc, lo} holds the exact product with no bits lost.
        acc_d = {sum[ACC_W-1], sum[ACC_W-1], sum[ACC_W-1:2]};
        lo_d  = {sum[1:0], lo_q[LO_W-1:2]};
        b_d   = {2'b00, b_q[ACC_W-1:2]};
        if (cnt_q == LAST_DIG) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign prod_lsb  = lo_q[WIDTH-1:0];
  assign prod_msb  = {acc_q[WIDTH-3:0], lo_q[LO_W-1:WIDTH]};
  assign out_tag   = tag_q;

endmodule

// File: tb/tb_booth_seq_mul.sv
// -----------------------------------------------------------------------------
// tb_booth_seq_mul
// Scoreboard bench for booth_seq_mul at WIDTH=32 (directed cases, back-pressure,
// mid-operation reset) and WIDTH=8 (directed case plus randomized traffic with
// random out_ready). Expected products come from a plain-arithmetic model.
// -----------------------------------------------------------------------------
module tb_booth_seq_mul;

  typedef struct {
    logic [63:0] prod;
    logic [3:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WIDTH=32 instance
  logic        in_valid32, in_ready32, s32, out_valid32, out_ready32;
  logic [31:0] a32, b32, msb32, lsb32;
  logic [3:0]  tag_in32, otag32;

  // WIDTH=8 instance
  logic        in_valid8, in_ready8, s8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, msb8, lsb8;
  logic [3:0]  tag_in8, otag8;

  exp_t q32[$];
  exp_t q8[$];
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy8 = 1'b0;

  booth_seq_mul #(.WIDTH(32), .TAG_W(4)) u_mul32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .alu_signed(s32), .in_tag(tag_in32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .prod_msb(msb32), .prod_lsb(lsb32), .out_tag(otag32)
  );

  booth_seq_mul #(.WIDTH(8), .TAG_W(4)) u_mul8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .alu_signed(s8), .in_tag(tag_in8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .prod_msb(msb8), .prod_lsb(lsb8), .out_tag(otag8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Reference: exact mathematical product of w-bit operands, truncated to 2w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [63:0] a,
                                          input logic [63:0] b, input bit s);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'(a);
    sb = longint'(b);
    if (s) begin
      sa = longint'(a << (64 - w)) >>> (64 - w);
      sb = longint'(b << (64 - w)) >>> (64 - w);
    end
    p = 64'(sa * sb);
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  // Monitors: a product is consumed on an edge where out_valid && out_ready.
  always @(negedge clk) begin : mon32
    exp_t e;
    if (rst_n && out_valid32 && out_ready32) begin
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb32_unexpected: got product 0x%0h, expected no output", {msb32, lsb32});
      end else begin
        e = q32.pop_front();
        check("sb32_prod", {msb32, lsb32}, e.prod);
        check("sb32_tag", 64'(otag32), 64'(e.tag));
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n && out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb8_unexpected: got product 0x%0h, expected no output", {msb8, lsb8});
      end else begin
        e = q8.pop_front();
        check("sb8_prod", 64'({msb8, lsb8}), e.prod);
        check("sb8_tag", 64'(otag8), 64'(e.tag));
      end
    end
  end

  // Random consumer for the WIDTH=8 traffic phase.
  initial begin
    wait (rand_rdy8);
    forever begin
      @(posedge clk);
      #1 out_ready8 = ($urandom_range(0, 3) != 0);
    end
  end

  // Returns just after the acceptance edge; operands are then scrambled to
  // show that later input changes do not affect the transaction.
  task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [3:0] tag);
    int n;
    @(posedge clk);
    #1;
    a32 = a; b32 = b; s32 = s; tag_in32 = tag; in_valid32 = 1'b1;
    n = 0;
    while (!in_ready32 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) timeout("issue32");
    q32.push_back('{ref_mul(32, {32'd0, a}, {32'd0, b}, s), tag});
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
    a32 = $urandom; b32 = $urandom; s32 = ~s; tag_in32 = ~tag;
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [3:0] tag);
    int n;
    #1;
    a8 = a; b8 = b; s8 = s; tag_in8 = tag; in_valid8 = 1'b1;
    n = 0;
    while (!in_ready8 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) timeout("issue8");
    q8.push_back('{ref_mul(8, {56'd0, a}, {56'd0, b}, s), tag});
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = ~s;
  endtask

  // Counts edges after acceptance until out_valid is seen.
  task automatic wait_valid32(output int lat);
    lat = 0;
    while (!out_valid32 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid32) timeout("wait_valid32");
  endtask

  task automatic wait_valid8(output int lat);
    lat = 0;
    while (!out_valid8 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid8) timeout("wait_valid8");
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    logic [63:0] held_p;
    logic [3:0]  held_t;

    rst_n = 1'b0;
    in_valid32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0; tag_in32 = '0; out_ready32 = 1'b1;
    in_valid8  = 1'b0; a8  = '0; b8  = '0; s8  = 1'b0; tag_in8  = '0; out_ready8  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready32), 64'd1);
    check("rst_out_valid", 64'(out_valid32), 64'd0);
    check("rst_prod", {msb32, lsb32}, 64'd0);
    check("rst_tag", 64'(otag32), 64'd0);
    check("rst8_in_ready", 64'(in_ready8), 64'd1);
    rst_n = 1'b1;

    // ---- WIDTH=32 directed ----
    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'h1);
    wait_valid32(lat);
    check("allones_u_latency", 64'(lat), 64'd17);
    check("allones_u_prod", {msb32, lsb32}, 64'hFFFF_FFFE_0000_0001);

    issue32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'h2);
    wait_valid32(lat);
    check("allones_s_latency", 64'(lat), 64'd17);
    check("allones_s_prod", {msb32, lsb32}, 64'h0000_0000_0000_0001);

    issue32(32'h8000_0000, 32'h0000_0002, 1'b1, 4'hA);
    wait_valid32(lat);
    check("msbset_s_prod", {msb32, lsb32}, 64'hFFFF_FFFF_0000_0000);
    check("msbset_s_tag", 64'(otag32), 64'hA);

    issue32(32'h8000_0000, 32'h0000_0002, 1'b0, 4'hA);
    wait_valid32(lat);
    check("msbset_u_prod", {msb32, lsb32}, 64'h0000_0001_0000_0000);
    check("msbset_u_tag", 64'(otag32), 64'hA);

    // ---- back-pressure ----
    @(posedge clk);
    #1 out_ready32 = 1'b0;
    issue32($urandom, $urandom, 1'b1, 4'h5);
    wait_valid32(lat);
    held_p = {msb32, lsb32};
    held_t = otag32;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_prod_stable", {msb32, lsb32}, held_p);
      check("bp_tag_stable", 64'(otag32), 64'(held_t));
      check("bp_in_ready_low", 64'(in_ready32), 64'd0);
      check("bp_out_valid_high", 64'(out_valid32), 64'd1);
    end
    out_ready32 = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", 64'(in_ready32), 64'd1);
    check("bp_release_out_valid", 64'(out_valid32), 64'd0);

    // ---- reset mid-operation, after digit 8 ----
    issue32($urandom, $urandom, 1'b0, 4'h3);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q32.delete();
    check("midrst_in_ready", 64'(in_ready32), 64'd1);
    check("midrst_out_valid", 64'(out_valid32), 64'd0);
    check("midrst_prod", {msb32, lsb32}, 64'd0);
    check("midrst_tag", 64'(otag32), 64'd0);
    issue32(32'd3, 32'd5, 1'b0, 4'h7);
    wait_valid32(lat);
    check("after_rst_lsb", 64'(lsb32), 64'd15);
    check("after_rst_msb", 64'(msb32), 64'd0);

    // ---- WIDTH=8 directed ----
    @(posedge clk);
    issue8(8'h7F, 8'h81, 1'b1, 4'hC);
    wait_valid8(lat);
    check("w8_latency", 64'(lat), 64'd5);
    check("w8_prod", 64'({msb8, lsb8}), 64'h0000_C0FF);
    @(posedge clk);

    // ---- WIDTH=8 randomized back-to-back traffic ----
    rand_rdy8 = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      issue8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 4'($urandom));
    end
    lat = 0;
    while (q8.size() != 0 && lat < 1000) begin
      @(posedge clk);
      lat++;
    end
    check("sb8_drained", 64'(q8.size()), 64'd0);
    check("sb32_drained", 64'(q32.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
